// File: rtl/flt2fix_unit.sv
// Half-precision float to 16-bit sign-magnitude 7.8 fixed-point converter.
// Serial shifter moves the significand one bit per cycle into place.
module flt2fix_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] flt_in,
   output logic        done,
   output logic        busy,
   output logic [15:0] fix_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] op_q, op_d;
   logic [14:0] sh_q, sh_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        dir_q, dir_d;
   logic [15:0] fix_q, fix_d;

   logic [4:0]  exp_w;
   logic [3:0]  p_w;
   logic        dir_init;
   logic [3:0]  cnt_init;
   logic [14:0] sh_init;
   logic [14:0] sh_next;

   // p is only used for 7<=e<=21, so a 4-bit wrap is harmless
   assign exp_w    = op_q[14:10];
   assign p_w      = exp_w[3:0] - 4'd7;
   assign dir_init = (p_w > 4'd10);
   assign cnt_init = dir_init ? (p_w - 4'd10) : (4'd10 - p_w);
   assign sh_init  = {4'b0000, 1'b1, op_q[9:0]};
   assign sh_next  = dir_q ? {sh_q[13:0], 1'b0}
                           : {1'b0, sh_q[14:1]};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      fix_d   = fix_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = flt_in;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // e>21 also covers inf/NaN (e=31)
            if (exp_w > 5'd21) begin
               fix_d   = {op_q[15], 15'h7FFF};
               state_d = S_DONE;
            end else if (exp_w < 5'd7) begin
               fix_d   = {op_q[15], 15'h0000};
               state_d = S_DONE;
            end else begin
               sh_d  = sh_init;
               dir_d = dir_init;
               cnt_d = cnt_init;
               if (cnt_init == 4'd0) begin
                  fix_d   = {op_q[15], sh_init};
                  state_d = S_DONE;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            sh_d  = sh_next;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               fix_d   = {op_q[15], sh_next};
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               op_d    = flt_in;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 16'h0000;
         sh_q    <= 15'h0000;
         cnt_q   <= 4'd0;
         dir_q   <= 1'b0;
         fix_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         fix_q   <= fix_d;
      end
   end

   assign busy    = (state_q == S_LOAD) || (state_q == S_SHIFT);
   assign done    = (state_q == S_DONE);
   assign fix_out = fix_q;

endmodule
